// File: rtl/wb_result_arbiter.sv
// Writeback result arbiter: each execution unit has a small result FIFO, and
// round-robin arbitration moves FIFO heads onto registered broadcast ports.

module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         not_empty,
  output logic         ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wp, rp;
  logic [CW-1:0]           cnt;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (kill) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= ptr_nxt(wp);
      if (pop)  rp <= ptr_nxt(rp);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; it is only read while cnt != 0.
  always_ff @(posedge clk) begin
    if (push && !kill) mem[wp] <= wdata;
  end

  assign rdata     = mem[rp];
  assign not_empty = (cnt != '0);
  assign ready     = (cnt != CW'(DEPTH));
endmodule

module wb_result_arbiter #(
  parameter int REQ_NUM   = 4,
  parameter int PORT_NUM  = 2,
  parameter int BUF_DEPTH = 2,
  parameter int DATA_LEN  = 32,
  parameter int RRF_SEL   = 6,
  localparam int SW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         kill_i,
  input  logic [REQ_NUM-1:0]           req_valid_i,
  output logic [REQ_NUM-1:0]           req_ready_o,
  input  logic [REQ_NUM*DATA_LEN-1:0]  req_data_i,
  input  logic [REQ_NUM*RRF_SEL-1:0]   req_dst_i,
  output logic [PORT_NUM-1:0]          res_valid_o,
  output logic [PORT_NUM*DATA_LEN-1:0] res_data_o,
  output logic [PORT_NUM*RRF_SEL-1:0]  res_dst_o,
  output logic [PORT_NUM*SW-1:0]       res_src_o,
  output logic                         pending_o
);
  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic [RRF_SEL-1:0]  dst;
  } wb_ent_t;

  wb_ent_t [REQ_NUM-1:0]          wr_ent, hd_ent;
  logic    [REQ_NUM-1:0]          ne, gnt;
  logic    [SW-1:0]               rr_ptr, last;
  logic    [PORT_NUM-1:0]         pvld, res_vld;
  logic    [PORT_NUM-1:0][SW-1:0] psel, res_src;
  wb_ent_t [PORT_NUM-1:0]         res_ent;
  int                             slot;

  for (genvar r = 0; r < REQ_NUM; r++) begin : g_req
    assign wr_ent[r] = '{data: req_data_i[r*DATA_LEN +: DATA_LEN],
                         dst:  req_dst_i[r*RRF_SEL +: RRF_SEL]};
    wb_result_fifo #(.DEPTH(BUF_DEPTH), .W(DATA_LEN + RRF_SEL)) u_fifo (
      .clk       (clk_i),
      .rst_n     (reset_i),
      .kill      (kill_i),
      .push      (req_valid_i[r] & req_ready_o[r]),
      .pop       (gnt[r]),
      .wdata     (wr_ent[r]),
      .rdata     (hd_ent[r]),
      .not_empty (ne[r]),
      .ready     (req_ready_o[r])
    );
  end

  function automatic logic [SW-1:0] rr_idx(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQ_NUM) s -= REQ_NUM;
    return SW'(s);
  endfunction

  // Walk requesters from rr_ptr; the k-th non-empty head goes to port k.
  always_comb begin
    gnt  = '0;
    pvld = '0;
    psel = '0;
    last = '0;
    slot = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (ne[rr_idx(rr_ptr, k)] && slot < PORT_NUM) begin
        gnt[rr_idx(rr_ptr, k)] = 1'b1;
        for (int p = 0; p < PORT_NUM; p++) begin
          if (slot == p) begin
            pvld[p] = 1'b1;
            psel[p] = rr_idx(rr_ptr, k);
          end
        end
        last = rr_idx(rr_ptr, k);
        slot = slot + 1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      res_vld <= '0;
      res_ent <= '0;
      res_src <= '0;
      rr_ptr  <= '0;
    end else if (kill_i) begin
      res_vld <= '0;
      res_ent <= '0;
      res_src <= '0;
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        res_vld[p] <= pvld[p];
        res_ent[p] <= pvld[p] ? hd_ent[psel[p]] : '0;
        res_src[p] <= psel[p];
      end
      if (|gnt) rr_ptr <= (last == SW'(REQ_NUM - 1)) ? '0 : last + 1'b1;
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    assign res_data_o[p*DATA_LEN +: DATA_LEN] = res_ent[p].data;
    assign res_dst_o[p*RRF_SEL +: RRF_SEL]    = res_ent[p].dst;
    assign res_src_o[p*SW +: SW]              = res_src[p];
  end

  assign res_valid_o = res_vld;
  assign pending_o   = |ne;
endmodule
